// File: rtl/vcve2_pkg.sv
// vcve2_pkg: shared definitions for the vector register file address generator.
//   VRF_START_ADDR : byte address of v0 word 0 in the memory map
//   agu_state_e    : AGU control states
//   lmul_e         : register group size encoding (1 << lmul registers)
//   reg_misaligned : true when a register index is not a multiple of the group size
package vcve2_pkg;

    localparam logic [31:0] VRF_START_ADDR = 32'h0000_1000;

    typedef enum logic [1:0] {
        AGU_IDLE = 2'd0,
        AGU_RUN  = 2'd1,
        AGU_DONE = 2'd2,
        AGU_ERR  = 2'd3
    } agu_state_e;

    typedef enum logic [1:0] {
        LMUL_1 = 2'd0,
        LMUL_2 = 2'd1,
        LMUL_4 = 2'd2,
        LMUL_8 = 2'd3
    } lmul_e;

    function automatic logic reg_misaligned(input logic [4:0] r, input logic [1:0] lmul);
        logic [4:0] mask;
        mask = (5'd1 << lmul) - 5'd1;
        return (r & mask) != 5'd0;
    endfunction

endpackage

// File: rtl/vcve2_vrf_agu_if.sv
// vcve2_vrf_agu_if: descriptor handshake, step/abort control and per-lane
// VRF address/valid outputs of the address generation unit.
//   slave  modport : the AGU (receives descriptors, drives addresses)
//   master modport : the decoder/controller side
interface vcve2_vrf_agu_if #(
    parameter int unsigned NumIfs    = 1,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdxW      = 7
);
    logic                                start_i;
    logic                                ready_o;
    logic [4:0]                          rs1_i;
    logic [4:0]                          rs2_i;
    logic [4:0]                          rd_i;
    logic                                use_rs1_i;
    logic                                use_rs2_i;
    logic                                use_rd_i;
    logic [1:0]                          lmul_i;
    logic                                slide_i;
    logic                                slide_up_i;
    logic [IdxW-1:0]                     offset_i;
    logic                                step_i;
    logic                                abort_i;
    logic [NumIfs-1:0][AddrWidth-1:0]    rs1_addr_o;
    logic [NumIfs-1:0][AddrWidth-1:0]    rs2_addr_o;
    logic [NumIfs-1:0][AddrWidth-1:0]    rd_addr_o;
    logic [NumIfs-1:0]                   rs1_valid_o;
    logic [NumIfs-1:0]                   rs2_valid_o;
    logic [NumIfs-1:0]                   rd_valid_o;
    logic                                busy_o;
    logic                                done_o;
    logic                                err_o;

    modport slave (
        input  start_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i, use_rd_i,
               lmul_i, slide_i, slide_up_i, offset_i, step_i, abort_i,
        output ready_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
               rs1_valid_o, rs2_valid_o, rd_valid_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i, use_rd_i,
               lmul_i, slide_i, slide_up_i, offset_i, step_i, abort_i,
        input  ready_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
               rs1_valid_o, rs2_valid_o, rd_valid_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/vcve2_agu_lane_addr.sv
// vcve2_agu_lane_addr: combinational element index, valid and byte address
// for one operand on one lane.
//   idx_i    : word index of lane 0 in the current beat
//   offset_i : slide offset in words
//   total_i  : words in the register group
//   reg_i    : base register of the group
//   en_i     : operand enabled and unit running
//   eshift_i : add offset to the element used for the address
//   vshift_i : add offset to the element used for the bounds test
//   valid_o  : lane carries a real element
//   addr_o   : byte address, 0 when the lane is invalid
module vcve2_agu_lane_addr
    import vcve2_pkg::*;
#(
    parameter int unsigned           AddrWidth   = 32,
    parameter int unsigned           VLEN        = 128,
    parameter int unsigned           Lane        = 0,
    parameter logic [AddrWidth-1:0]  VrfBaseAddr = AddrWidth'(VRF_START_ADDR),
    localparam int unsigned          IdxW        = $clog2(VLEN),
    localparam int unsigned          SW          = IdxW + 2
) (
    input  logic [SW-1:0]         idx_i,
    input  logic [IdxW-1:0]       offset_i,
    input  logic [SW-1:0]         total_i,
    input  logic [4:0]            reg_i,
    input  logic                  en_i,
    input  logic                  eshift_i,
    input  logic                  vshift_i,
    output logic                  valid_o,
    output logic [AddrWidth-1:0]  addr_o
);
    localparam int unsigned W = VLEN / 32;

    logic [SW-1:0] k;
    logic [SW-1:0] k_off;
    logic [SW-1:0] k_addr;
    logic [SW-1:0] k_bound;
    logic [SW-1:0] word;

    // Sums are kept wide enough that k + offset can never wrap.
    assign k       = idx_i + SW'(Lane);
    assign k_off   = k + SW'(offset_i);
    assign k_addr  = eshift_i ? k_off : k;
    assign k_bound = vshift_i ? k_off : k;
    assign valid_o = en_i && (k_bound < total_i);
    assign word    = SW'(reg_i) * SW'(W) + k_addr;
    assign addr_o  = valid_o ? (VrfBaseAddr + (AddrWidth'(word) << 2)) : '0;

endmodule

// File: rtl/vcve2_vrf_agu.sv
// vcve2_vrf_agu: address generation unit for the memory-mapped vector
// register file. Accepts one descriptor per start handshake and walks the
// rs1/rs2/rd register groups NumIfs words per beat, with LMUL grouping,
// slide up/down by an arbitrary word offset, abort and done/err pulses.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : descriptor handshake, step/abort, per-lane addresses/valids,
//                   busy/done/err status (see vcve2_vrf_agu_if)
module vcve2_vrf_agu
    import vcve2_pkg::*;
#(
    parameter int unsigned           NumIfs      = 1,
    parameter int unsigned           AddrWidth   = 32,
    parameter int unsigned           VLEN        = 128,
    parameter logic [AddrWidth-1:0]  VrfBaseAddr = AddrWidth'(VRF_START_ADDR)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    vcve2_vrf_agu_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(VLEN);
    localparam int unsigned SW   = IdxW + 2;
    localparam int unsigned W    = VLEN / 32;

    localparam logic [1:0] S_IDLE = AGU_IDLE;
    localparam logic [1:0] S_RUN  = AGU_RUN;
    localparam logic [1:0] S_DONE = AGU_DONE;
    localparam logic [1:0] S_ERR  = AGU_ERR;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    idx_q, idx_d;

    // Descriptor captured on accept; only observed while running.
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic             use_rs1_q, use_rs2_q, use_rd_q;
    lmul_e            lmul_q;
    logic             slide_q, slide_up_q;
    logic [IdxW-1:0]  offset_q;

    logic             accept;
    logic             bad_desc;
    logic [SW-1:0]    in_total;
    logic             up_skip;
    logic [SW-1:0]    total;
    logic [SW-1:0]    step_sum;
    logic [SW-1:0]    end_sum;
    logic             last_beat;
    logic             run;

    assign accept = bus.start_i && (state_q == S_IDLE);

    assign bad_desc = (bus.use_rs1_i && reg_misaligned(bus.rs1_i, bus.lmul_i)) ||
                      (bus.use_rs2_i && reg_misaligned(bus.rs2_i, bus.lmul_i)) ||
                      (bus.use_rd_i  && reg_misaligned(bus.rd_i,  bus.lmul_i));

    // A slide-up whose offset covers the whole group writes nothing.
    assign in_total = SW'(W) << bus.lmul_i;
    assign up_skip  = bus.slide_i && bus.slide_up_i && (SW'(bus.offset_i) >= in_total);

    assign total    = SW'(W) << lmul_q;
    assign step_sum = idx_q + SW'(NumIfs);
    // Slide-up stops once the shifted destination index passes the group end.
    assign end_sum  = (slide_q && slide_up_q) ? (step_sum + SW'(offset_q)) : step_sum;
    assign last_beat = end_sum >= total;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d = '0;
                    if (bad_desc) begin
                        state_d = S_ERR;
                    end else if (up_skip) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (bus.step_i) begin
                    idx_d = step_sum;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            rs1_q      <= bus.rs1_i;
            rs2_q      <= bus.rs2_i;
            rd_q       <= bus.rd_i;
            use_rs1_q  <= bus.use_rs1_i;
            use_rs2_q  <= bus.use_rs2_i;
            use_rd_q   <= bus.use_rd_i;
            lmul_q     <= lmul_e'(bus.lmul_i);
            slide_q    <= bus.slide_i;
            slide_up_q <= bus.slide_up_i;
            offset_q   <= bus.offset_i;
        end
    end

    assign run         = (state_q == S_RUN);
    assign bus.ready_o = (state_q == S_IDLE);
    assign bus.busy_o  = run;
    assign bus.done_o  = (state_q == S_DONE);
    assign bus.err_o   = (state_q == S_ERR);

    // Slide-down reads rs2 shifted by the offset; slide-up writes rd shifted,
    // and rs2 lanes follow the rd lane valid so both sides stay in lockstep.
    logic rs2_eshift, rs2_vshift, rd_shift;
    assign rs2_eshift = slide_q && !slide_up_q;
    assign rs2_vshift = slide_q;
    assign rd_shift   = slide_q && slide_up_q;

    logic [NumIfs-1:0]                rs1_v, rs2_v, rd_v;
    logic [NumIfs-1:0][AddrWidth-1:0] rs1_a, rs2_a, rd_a;

    for (genvar i = 0; i < NumIfs; i++) begin : g_lane
        vcve2_agu_lane_addr #(
            .AddrWidth(AddrWidth), .VLEN(VLEN), .Lane(i), .VrfBaseAddr(VrfBaseAddr)
        ) u_rs1 (
            .idx_i(idx_q), .offset_i(offset_q), .total_i(total), .reg_i(rs1_q),
            .en_i(run && use_rs1_q), .eshift_i(1'b0), .vshift_i(1'b0),
            .valid_o(rs1_v[i]), .addr_o(rs1_a[i])
        );
        vcve2_agu_lane_addr #(
            .AddrWidth(AddrWidth), .VLEN(VLEN), .Lane(i), .VrfBaseAddr(VrfBaseAddr)
        ) u_rs2 (
            .idx_i(idx_q), .offset_i(offset_q), .total_i(total), .reg_i(rs2_q),
            .en_i(run && use_rs2_q), .eshift_i(rs2_eshift), .vshift_i(rs2_vshift),
            .valid_o(rs2_v[i]), .addr_o(rs2_a[i])
        );
        vcve2_agu_lane_addr #(
            .AddrWidth(AddrWidth), .VLEN(VLEN), .Lane(i), .VrfBaseAddr(VrfBaseAddr)
        ) u_rd (
            .idx_i(idx_q), .offset_i(offset_q), .total_i(total), .reg_i(rd_q),
            .en_i(run && use_rd_q), .eshift_i(rd_shift), .vshift_i(rd_shift),
            .valid_o(rd_v[i]), .addr_o(rd_a[i])
        );
    end

    assign bus.rs1_valid_o = rs1_v;
    assign bus.rs2_valid_o = rs2_v;
    assign bus.rd_valid_o  = rd_v;
    assign bus.rs1_addr_o  = rs1_a;
    assign bus.rs2_addr_o  = rs2_a;
    assign bus.rd_addr_o   = rd_a;

endmodule
